// File: rtl/seg_display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : seg_display_scan
//  Description : Six-digit multiplexed 7-segment scanner for a stopwatch
//                (mm.ss.cc). Walks positions 5..0, blanks the anodes at the
//                start of each slot against ghosting, and shows a per-frame
//                snapshot of the BCD inputs that can be frozen for lap view.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_display_scan #(
   parameter int unsigned SCAN_DIV  = 100000,
   parameter int unsigned BLANK_CYC = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] min_10,
   input  logic [3:0] min_1,
   input  logic [3:0] sec_10,
   input  logic [3:0] sec_1,
   input  logic [3:0] milli_10,
   input  logic [3:0] milli_1,
   input  logic       freeze,
   input  logic       blank_lz,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_tick
);

   // Prescaler width covers 0..SCAN_DIV-1
   localparam int unsigned PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
   localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
   localparam logic [PRESC_W-1:0] BLANK_LIM  = PRESC_W'(BLANK_CYC);

   localparam logic [2:0] IDX_FIRST = 3'd5;
   localparam logic [2:0] IDX_LAST  = 3'd0;
   localparam logic [5:0] AN_OFF    = 6'h3F;
   localparam logic [6:0] SEG_OFF   = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   logic [PRESC_W-1:0] presc;
   logic [2:0]         idx;
   logic [5:0][3:0]    snap;

   logic               slot_end;
   logic               frame_end;
   logic               in_guard;
   logic               lz_blank;
   logic               slot_blank;
   logic [3:0]         cur_digit;
   logic [5:0]         an_next;
   logic [6:0]         seg_next;
   logic               dp_next;

   // BCD to active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash
   function automatic logic [6:0] decode_digit(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

   assign slot_end  = (presc == PRESC_LAST);
   assign frame_end = slot_end && (idx == IDX_LAST);

   // Free-running slot prescaler, wraps on the last cycle of each slot
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc <= '0;
      end else if (slot_end) begin
         presc <= '0;
      end else begin
         presc <= presc + PRESC_ONE;
      end
   end

   // Digit index walks 5 down to 0, then back to 5, one step per slot
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx <= IDX_FIRST;
      end else if (slot_end) begin
         if (idx == IDX_LAST) begin
            idx <= IDX_FIRST;
         end else begin
            idx <= idx - 3'd1;
         end
      end
   end

   // Snapshot is sampled only at frame boundaries, and only when not frozen,
   // so a freeze edge mid-frame can never tear the displayed value
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         snap <= '0;
      end else if (frame_end && !freeze) begin
         snap <= {min_10, min_1, sec_10, sec_1, milli_10, milli_1};
      end
   end

   // Anti-ghosting guard at the start of every slot (absent when BLANK_CYC=0)
   generate
      if (BLANK_CYC == 0) begin : g_no_guard
         assign in_guard = 1'b0;
      end else begin : g_guard
         assign in_guard = (presc < BLANK_LIM);
      end
   endgenerate

   // Leading-zero suppression applies only to the tens-of-minutes position
   assign lz_blank   = blank_lz && (idx == IDX_FIRST) && (snap[5] == 4'd0);
   assign slot_blank = in_guard || lz_blank;

   // Select the snapshot digit for the active position
   always_comb begin
      cur_digit = 4'd0;
      case (idx)
         3'd5:    cur_digit = snap[5];
         3'd4:    cur_digit = snap[4];
         3'd3:    cur_digit = snap[3];
         3'd2:    cur_digit = snap[2];
         3'd1:    cur_digit = snap[1];
         3'd0:    cur_digit = snap[0];
         default: cur_digit = 4'd0;
      endcase
   end

   // Next pin values: single low anode, decoded segments, dp after mm and ss
   always_comb begin
      an_next  = AN_OFF;
      seg_next = SEG_OFF;
      dp_next  = 1'b1;
      if (!slot_blank && (idx <= IDX_FIRST)) begin
         an_next  = ~(6'b00_0001 << idx);
         seg_next = decode_digit(cur_digit);
         dp_next  = !((idx == 3'd4) || (idx == 3'd2));
      end
   end

   // Registered pins: one clock behind the prescaler/index state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         an         <= AN_OFF;
         seg        <= SEG_OFF;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         an         <= an_next;
         seg        <= seg_next;
         dp         <= dp_next;
         frame_tick <= frame_end && !freeze;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_display_scan
//  Description : Self-checking bench for seg_display_scan (SCAN_DIV=8,
//                BLANK_CYC=2). Stimulus queues cycle-stamped expected pin
//                values; a monitor compares them as the cycles arrive.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_scan;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] min_10 = 4'd0, min_1 = 4'd0, sec_10 = 4'd0;
   logic [3:0] sec_1 = 4'd0, milli_10 = 4'd0, milli_1 = 4'd0;
   logic       freeze = 1'b0;
   logic       blank_lz = 1'b0;
   logic [5:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_tick;

   seg_display_scan #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .min_10     (min_10),
      .min_1      (min_1),
      .sec_10     (sec_10),
      .sec_1      (sec_1),
      .milli_10   (milli_10),
      .milli_1    (milli_1),
      .freeze     (freeze),
      .blank_lz   (blank_lz),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [5:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       ft;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc;

   // Cycles since reset release: pins seen at negedge after edge n carry cyc=n
   always @(posedge clk or negedge reset) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string nm,
                        input logic [5:0] a_g, input logic [5:0] a_e,
                        input logic [6:0] s_g, input logic [6:0] s_e,
                        input logic d_g, input logic d_e,
                        input logic f_g, input logic f_e);
      n_checks++;
      if ({a_g, s_g, d_g, f_g} !== {a_e, s_e, d_e, f_e}) begin
         n_fail++;
         $display("FAIL %s: got an=%h seg=%h dp=%b ft=%b, expected an=%h seg=%h dp=%b ft=%b",
                  nm, a_g, s_g, d_g, f_g, a_e, s_e, d_e, f_e);
      end
   endtask

   task automatic push(input int c, input logic [5:0] a, input logic [6:0] s,
                       input logic d, input logic f, input string nm);
      exp_t e;
      e.cyc = c; e.an = a; e.seg = s; e.dp = d; e.ft = f; e.name = nm;
      sb.push_back(e);
   endtask

   // Monitor: compare queued expectations when their cycle is presented
   always @(negedge clk) begin
      if (reset) begin
         n_checks++;
         if (!$onehot0(~an)) begin
            n_fail++;
            $display("FAIL one_anode at cyc %0d: an=%h, required at most one low bit", cyc, an);
         end
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < cyc) begin
               n_checks++;
               n_fail++;
               $display("FAIL %s: expectation for cyc %0d missed, now cyc %0d", e.name, e.cyc, cyc);
            end else begin
               check($sformatf("%s@%0d", e.name, e.cyc), an, e.an, seg, e.seg, dp, e.dp, frame_tick, e.ft);
            end
         end
      end
   end

   task automatic set_digits(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                             input logic [3:0] d, input logic [3:0] e, input logic [3:0] f);
      min_10 = a; min_1 = b; sec_10 = c; sec_1 = d; milli_10 = e; milli_1 = f;
   endtask

   task automatic enter_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations never presented, required 0", sb.size());
         sb.delete();
      end
   endtask

   logic [5:0] f2_an  [6] = '{6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E};
   logic [6:0] f2_seg [6] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
   logic       f2_dp  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

   initial begin
      // ---- Phase A: reset state, frame-1 zeros, frame-2 digits 1..6 ----
      set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
      enter_reset();
      check("reset_state", an, 6'h3F, seg, 7'h7F, dp, 1'b1, frame_tick, 1'b0);
      push(1,  6'h3F, 7'h7F, 1'b1, 1'b0, "A_f1_guard");
      push(3,  6'h1F, 7'h40, 1'b1, 1'b0, "A_f1_pos5_zero");
      push(47, 6'h3E, 7'h40, 1'b1, 1'b0, "A_f1_pos0");
      push(48, 6'h3E, 7'h40, 1'b1, 1'b1, "A_first_tick");
      for (int k = 0; k < 6; k++) begin
         push(50 + 8*k, 6'h3F, 7'h7F, 1'b1, 1'b0, $sformatf("A_f2_guard%0d", k));
         push(51 + 8*k, f2_an[k], f2_seg[k], f2_dp[k], 1'b0, $sformatf("A_f2_first%0d", k));
         push(56 + 8*k, f2_an[k], f2_seg[k], f2_dp[k], k == 5, $sformatf("A_f2_last%0d", k));
      end
      push(144, 6'h3E, 7'h02, 1'b1, 1'b1, "A_tick_period");
      @(negedge clk);
      reset = 1'b1;
      drain();

      // ---- Phase B: freeze holds the snapshot across a frame boundary ----
      enter_reset();
      set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
      freeze = 1'b0;
      push(48,  6'h3E, 7'h40, 1'b1, 1'b1, "B_tick");
      push(96,  6'h3E, 7'h02, 1'b1, 1'b0, "B_frozen_no_tick");
      push(99,  6'h1F, 7'h79, 1'b1, 1'b0, "B_frozen_pos5");
      push(107, 6'h2F, 7'h24, 1'b0, 1'b0, "B_frozen_pos4");
      push(144, 6'h3E, 7'h02, 1'b1, 1'b1, "B_unfreeze_tick");
      push(147, 6'h1F, 7'h10, 1'b1, 1'b0, "B_nines_pos5");
      push(171, 6'h3B, 7'h10, 1'b0, 1'b0, "B_nines_pos2");
      reset = 1'b1;
      wait_cyc(60);
      freeze = 1'b1;
      wait_cyc(62);
      set_digits(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
      wait_cyc(120);
      freeze = 1'b0;
      drain();

      // ---- Phase C: leading-zero blanking of position 5 ----
      enter_reset();
      set_digits(4'd0, 4'd7, 4'd3, 4'd4, 4'd5, 4'd6);
      blank_lz = 1'b1;
      push(3,   6'h3F, 7'h7F, 1'b1, 1'b0, "C_lz_f1_start");
      push(8,   6'h3F, 7'h7F, 1'b1, 1'b0, "C_lz_f1_end");
      push(11,  6'h2F, 7'h40, 1'b0, 1'b0, "C_pos4_zero");
      push(51,  6'h3F, 7'h7F, 1'b1, 1'b0, "C_lz_f2_start");
      push(56,  6'h3F, 7'h7F, 1'b1, 1'b0, "C_lz_f2_end");
      push(59,  6'h2F, 7'h78, 1'b0, 1'b0, "C_pos4_seven");
      push(147, 6'h1F, 7'h40, 1'b1, 1'b0, "C_nolz_start");
      push(152, 6'h1F, 7'h40, 1'b1, 1'b0, "C_nolz_end");
      reset = 1'b1;
      wait_cyc(110);
      blank_lz = 1'b0;
      drain();

      // ---- Phase D: invalid BCD shows a dash, anode still driven ----
      enter_reset();
      set_digits(4'd1, 4'd2, 4'd3, 4'd12, 4'd4, 4'd15);
      push(75, 6'h3B, 7'h3F, 1'b0, 1'b0, "D_dash_pos2_start");
      push(80, 6'h3B, 7'h3F, 1'b0, 1'b0, "D_dash_pos2_end");
      push(83, 6'h3D, 7'h19, 1'b1, 1'b0, "D_pos1_four");
      push(91, 6'h3E, 7'h3F, 1'b1, 1'b0, "D_dash_pos0");
      push(96, 6'h3E, 7'h3F, 1'b1, 1'b1, "D_dash_pos0_tick");
      push(99, 6'h1F, 7'h79, 1'b1, 1'b0, "D_pos5_lit");
      reset = 1'b1;
      wait_cyc(99);

      // ---- Phase E: asynchronous reset mid-slot, then restart at pos 5 ----
      #2 reset = 1'b0;
      #1 check("async_reset", an, 6'h3F, seg, 7'h7F, dp, 1'b1, frame_tick, 1'b0);
      drain();
      repeat (3) @(negedge clk);
      push(1, 6'h3F, 7'h7F, 1'b1, 1'b0, "E_restart_guard");
      push(3, 6'h1F, 7'h40, 1'b1, 1'b0, "E_restart_pos5");
      push(8, 6'h1F, 7'h40, 1'b1, 1'b0, "E_restart_pos5_end");
      reset = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg_display_scan.md
SEG_DISPLAY_SCAN -- requirements
Module: seg_display_scan

Interface
REQ-001 Parameter SCAN_DIV, default 100000, meaning clk cycles per digit slot (legal 4..2^20).
REQ-002 Parameter BLANK_CYC, default 1000, meaning anode-off cycles at slot start, anti-ghosting (legal 0..SCAN_DIV-1).
REQ-003 clk  input  1  system clock; sole clock domain.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 min_10, min_1, sec_10, sec_1, milli_10, milli_1  input  4 each  BCD digits from stopwatch, display positions 5..0 left to right.
REQ-006 freeze  input  1  level; while high, displayed snapshot is held (lap view).
REQ-007 blank_lz  input  1  level; enables leading-zero blanking of position 5.
REQ-008 an  output  6  active-low anode enables, bit i = position i.
REQ-009 seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-010 dp  output  1  active-low decimal point.
REQ-011 frame_tick  output  1  one-cycle pulse each time the snapshot is reloaded.

Function
REQ-012 Prescaler counts 0..SCAN_DIV-1, wraps to 0; wrap cycle = slot_end.
REQ-013 Digit index counts 5,4,3,2,1,0, then back to 5; advances only on slot_end.
REQ-014 Snapshot: six 4-bit registers; loaded from the six inputs on the slot_end that moves index 0 to 5, only when freeze=0 that cycle.
REQ-015 frame_tick asserts the cycle after each snapshot load; no pulse when the load is suppressed by freeze.
REQ-016 freeze rising or falling mid-frame never changes snapshot contents within the frame; only frame boundaries sample freeze.
REQ-017 Decode (hex, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; values 10..15 display dash = 3F.
REQ-018 dp low for positions 4 and 2 (mm.ss.cc), high otherwise.
REQ-019 Blank slot: prescaler < BLANK_CYC, or (blank_lz=1 and index=5 and snapshot[5]=0); blank forces an=3F hex (all off), seg=7F, dp=1.
REQ-020 Non-blank slot: an has exactly one zero at bit index; seg/dp per decoded snapshot digit.
REQ-021 Never more than one an bit low in any cycle.
REQ-022 an, seg, dp, frame_tick are registered; pin values lag prescaler/index state by exactly one clk.
REQ-023 Invalid-BCD digit still drives its anode (dash shown), not blanked.
REQ-024 Prescaler and index are free-running; freeze and blank_lz do not stop the scan.

Reset
REQ-025 reset low asynchronously sets prescaler=0, index=5, snapshot all 0, an=3F hex, seg=7F, dp=1, frame_tick=0.
REQ-026 Reset deasserted: first snapshot load occurs at the end of the first full six-slot frame; position 5 slot starts immediately, showing 0 after BLANK_CYC (unless blank_lz).
REQ-027 reset mid-slot abandons the slot; outputs reach reset values with no clock required.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-028 Inputs 1,2,3,4,5,6, release reset, run 2 frames -> frame 2 slots show an=1F,2F,37,3B,3D,3E with seg 79,24,30,19,12,02; dp low on 2nd and 4th slots.
REQ-029 Each slot -> first 2 cycles an=3F, following 6 cycles one anode low; frame length 48 cycles; frame_tick period 48.
REQ-030 freeze=1 before frame boundary, then change inputs to 9s -> display keeps old digits, no frame_tick; freeze=0 -> 9s (seg 10) appear from next frame.
REQ-031 min_10=0, blank_lz=1 -> position-5 slot an=3F whole slot; min_10=0, blank_lz=0 -> seg=40 shown.
REQ-032 sec_1=12 (invalid) -> position 2 seg=3F, an=3B, dp=0.
REQ-033 Assert reset mid-slot without clock edge -> an=3F, seg=7F, dp=1 immediately; after release, scan restarts at position 5.
